// File: rtl/mmcm_reconfig_seq.sv
// Sequencer for MMCM mode changes. It takes requests from system control, issues one
// engine request per attempt, then watches the MMCM unlock, relock and settle.
module mmcm_reconfig_seq #(
  parameter int RSEL_WIDTH    = 1,
  parameter int ADDR_WIDTH    = 5,
  parameter int CFG_COUNT     = 22,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 255,
  parameter int MAX_RETRY     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RSEL_WIDTH-1:0] req_mode,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [RSEL_WIDTH-1:0] cur_mode,
  output logic                  cur_mode_valid,
  output logic [RSEL_WIDTH-1:0] m_baddr,
  output logic [ADDR_WIDTH-1:0] m_count,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  locked
);

  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    ST_BOOT        = 3'd0,
    ST_IDLE        = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT_UNLOCK = 3'd3,
    ST_WAIT_LOCK   = 3'd4,
    ST_SETTLE      = 3'd5,
    ST_FAIL        = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic                  lk_meta_q, lk_meta_d;
  logic                  lk_q, lk_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [SW-1:0]         scnt_q, scnt_d;
  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic [RSEL_WIDTH-1:0] m_baddr_q, m_baddr_d;
  logic [ADDR_WIDTH-1:0] m_count_q, m_count_d;
  logic                  m_valid_q, m_valid_d;
  logic                  req_ready_q, req_ready_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [RSEL_WIDTH-1:0] cur_mode_q, cur_mode_d;
  logic                  cur_mode_valid_q, cur_mode_valid_d;
  logic                  accept;
  logic                  timeout;
  logic                  retry_ok;
  logic                  settled;

  assign timeout  = (tcnt_q == TW'(LOCK_TIMEOUT - 1));
  assign retry_ok = (rcnt_q < RW'(MAX_RETRY));
  assign settled  = (scnt_q == SW'(SETTLE_CYCLES - 1));

  always_comb begin
    state_d          = state_q;
    lk_meta_d        = locked;
    lk_d             = lk_meta_q;
    tcnt_d           = tcnt_q;
    scnt_d           = scnt_q;
    rcnt_d           = rcnt_q;
    m_baddr_d        = m_baddr_q;
    m_count_d        = ADDR_WIDTH'(CFG_COUNT);
    done_d           = 1'b0;
    error_d          = error_q;
    cur_mode_d       = cur_mode_q;
    cur_mode_valid_d = cur_mode_valid_q;
    accept           = 1'b0;

    if (state_q == ST_ISSUE || state_q == ST_WAIT_UNLOCK || state_q == ST_WAIT_LOCK) begin
      tcnt_d = tcnt_q + TW'(1);
    end

    case (state_q)
      // Power-up lock time is unbounded, so only the settle run matters here.
      ST_BOOT: begin
        if (!lk_q) begin
          scnt_d = '0;
        end else if (settled) begin
          state_d = ST_IDLE;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          accept = 1'b1;
          if (cur_mode_valid_q && req_mode == cur_mode_q) begin
            done_d = 1'b1;
          end else begin
            m_baddr_d = req_mode;
            error_d   = 1'b0;
            rcnt_d    = '0;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (m_valid_q && m_ready) begin
          state_d = ST_WAIT_UNLOCK;
        end else if (timeout) begin
          state_d = ST_FAIL;
        end
      end
      ST_WAIT_UNLOCK: begin
        if (!lk_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (timeout) begin
          if (retry_ok) begin
            rcnt_d  = rcnt_q + RW'(1);
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_WAIT_LOCK: begin
        if (lk_q) begin
          state_d = ST_SETTLE;
        end else if (timeout) begin
          if (retry_ok) begin
            rcnt_d  = rcnt_q + RW'(1);
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      // A lock drop while settling restarts the lock wait without spending a retry.
      ST_SETTLE: begin
        if (!lk_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (settled) begin
          cur_mode_d       = m_baddr_q;
          cur_mode_valid_d = 1'b1;
          done_d           = 1'b1;
          state_d          = ST_IDLE;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      ST_FAIL: begin
        error_d          = 1'b1;
        cur_mode_valid_d = 1'b0;
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_FAIL;
      end
    endcase

    if (state_d != state_q) begin
      tcnt_d = '0;
      scnt_d = '0;
    end

    m_valid_d   = (state_d == ST_ISSUE);
    // Ready only after a full cycle in IDLE, so a done cycle never accepts.
    req_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE) && !accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_BOOT;
      lk_meta_q        <= 1'b0;
      lk_q             <= 1'b0;
      tcnt_q           <= '0;
      scnt_q           <= '0;
      rcnt_q           <= '0;
      m_baddr_q        <= '0;
      m_count_q        <= '0;
      m_valid_q        <= 1'b0;
      req_ready_q      <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      cur_mode_q       <= '0;
      cur_mode_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      lk_meta_q        <= lk_meta_d;
      lk_q             <= lk_d;
      tcnt_q           <= tcnt_d;
      scnt_q           <= scnt_d;
      rcnt_q           <= rcnt_d;
      m_baddr_q        <= m_baddr_d;
      m_count_q        <= m_count_d;
      m_valid_q        <= m_valid_d;
      req_ready_q      <= req_ready_d;
      done_q           <= done_d;
      error_q          <= error_d;
      cur_mode_q       <= cur_mode_d;
      cur_mode_valid_q <= cur_mode_valid_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign error          = error_q;
  assign cur_mode       = cur_mode_q;
  assign cur_mode_valid = cur_mode_valid_q;
  assign m_baddr        = m_baddr_q;
  assign m_count        = m_count_q;
  assign m_valid        = m_valid_q;

endmodule

// File: tb/tb_mmcm_reconfig_seq.sv
// Bench for mmcm_reconfig_seq: engine and MMCM models, a table of requests, corner-case
// sequences and random requests checked against an outcome-level reference model.
module tb_mmcm_reconfig_seq;

  localparam int RSEL = 2;
  localparam int AW   = 5;
  localparam int CFG  = 22;
  localparam int LT   = 100;
  localparam int SC   = 40;
  localparam int MR   = 3;

  typedef enum int {K_OK, K_NOUNLOCK, K_NOLOCK, K_NOREADY} kind_t;

  typedef struct {
    logic [RSEL-1:0] mode;
    int              eng_delay;
    kind_t           kind;
    int              un_delay;
    int              un_len;
    int              exp_hs;
    bit              exp_done;
    bit              exp_err;
    logic [RSEL-1:0] exp_cur;
    bit              exp_cur_valid;
  } vec_t;

  logic            clk;
  logic            reset;
  logic [RSEL-1:0] req_mode;
  logic            req_valid;
  logic            req_ready;
  logic            busy;
  logic            done;
  logic            error;
  logic [RSEL-1:0] cur_mode;
  logic            cur_mode_valid;
  logic [RSEL-1:0] m_baddr;
  logic [AW-1:0]   m_count;
  logic            m_valid;
  logic            m_ready;
  logic            locked;

  mmcm_reconfig_seq #(
    .RSEL_WIDTH(RSEL), .ADDR_WIDTH(AW), .CFG_COUNT(CFG),
    .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .req_mode(req_mode), .req_valid(req_valid),
    .req_ready(req_ready), .busy(busy), .done(done), .error(error),
    .cur_mode(cur_mode), .cur_mode_valid(cur_mode_valid), .m_baddr(m_baddr),
    .m_count(m_count), .m_valid(m_valid), .m_ready(m_ready), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt, done_cnt, first_done, mv_seen;
  int lo_start = 0, lo_end = 0, glitch_at = -1, glitch_off = 0;
  int cur_delay = 0, un_delay = 0, un_len = 0, rdy_cnt = 0;
  kind_t cur_kind = K_OK;

  // Reference model: outcome of each request in terms of mode bookkeeping only.
  logic [RSEL-1:0] model_cur   = '0;
  logic [RSEL-1:0] model_baddr = '0;
  bit              model_valid = 1'b0;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock: advance, then update the engine/MMCM models and run per-cycle invariants.
  task automatic step();
    bit hs, hold, rst_prev;
    logic [RSEL-1:0] b_prev;
    hs       = (m_valid === 1'b1) && (m_ready === 1'b1);
    hold     = (m_valid === 1'b1) && (m_ready !== 1'b1);
    rst_prev = reset;
    b_prev   = m_baddr;
    @(posedge clk);
    #1;
    cyc++;
    if (hs && !rst_prev) begin
      hs_cnt++;
      if (cur_kind == K_OK) begin
        lo_start = cyc + un_delay;
        lo_end   = lo_start + un_len;
        if (glitch_off > 0) glitch_at = lo_end + 3 + glitch_off;
      end else if (cur_kind == K_NOLOCK) begin
        lo_start = cyc;
        lo_end   = 1 << 30;
      end
    end
    locked = !((cyc >= lo_start && cyc < lo_end) || cyc == glitch_at);
    if (m_valid === 1'b1) begin
      rdy_cnt++;
      m_ready = (rdy_cnt > cur_delay);
      mv_seen = 1;
    end else begin
      rdy_cnt = 0;
      m_ready = 1'b0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (first_done < 0) first_done = cyc;
    end
    check("done_error_exclusive", done & error, 0);
    check("ready_implies_idle", req_ready & busy, 0);
    if (hold && !rst_prev && m_valid === 1'b1) check("baddr_stable", m_baddr, b_prev);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_cur_mode"}, cur_mode, 0);
    check({tag, "_cur_mode_valid"}, cur_mode_valid, 0);
    check({tag, "_m_baddr"}, m_baddr, 0);
    check({tag, "_m_count"}, m_count, 0);
    check({tag, "_m_valid"}, m_valid, 0);
  endtask

  task automatic do_boot(input string tag);
    int n, busy_fall;
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (4) step();
    check_reset_vals(tag);
    reset     = 1'b0;
    n         = 0;
    busy_fall = -1;
    for (int i = 0; i < SC + 50; i++) begin
      step();
      n++;
      if (busy === 1'b0 && busy_fall < 0) busy_fall = n;
      if (req_ready === 1'b1) break;
    end
    check_range({tag, "_ready_rise"}, n, SC + 2, SC + 4);
    check_range({tag, "_busy_fall"}, busy_fall, SC + 1, SC + 3);
    check({tag, "_cur_mode_valid"}, cur_mode_valid, 0);
    $display("boot %s: req_ready after %0d cycles, busy low after %0d", tag, n, busy_fall);
    model_cur   = '0;
    model_baddr = '0;
    model_valid = 1'b0;
  endtask

  function automatic vec_t mkv(input logic [RSEL-1:0] mode, input int d, input kind_t k,
                               input int ud, input int ul, input int hs, input bit dn,
                               input bit er, input logic [RSEL-1:0] cur, input bit cv);
    vec_t v;
    v.mode = mode; v.eng_delay = d; v.kind = k; v.un_delay = ud; v.un_len = ul;
    v.exp_hs = hs; v.exp_done = dn; v.exp_err = er; v.exp_cur = cur; v.exp_cur_valid = cv;
    return v;
  endfunction

  function automatic vec_t predict(input vec_t v);
    vec_t r;
    r = v;
    if (model_valid && v.mode == model_cur) begin
      r.exp_hs = 0; r.exp_done = 1; r.exp_err = 0; r.exp_cur = model_cur; r.exp_cur_valid = 1;
    end else if (v.kind == K_OK) begin
      r.exp_hs = 1; r.exp_done = 1; r.exp_err = 0; r.exp_cur = v.mode; r.exp_cur_valid = 1;
    end else begin
      r.exp_hs = (v.kind == K_NOREADY) ? 0 : 1 + MR;
      r.exp_done = 0; r.exp_err = 1; r.exp_cur = model_cur; r.exp_cur_valid = 0;
    end
    return r;
  endfunction

  task automatic run_req(input string tag, input vec_t v);
    bit reconfig, accepted, go;
    reconfig   = !(model_valid && v.mode == model_cur);
    cur_kind   = v.kind;
    cur_delay  = (v.kind == K_NOREADY) ? (1 << 30) : v.eng_delay;
    un_delay   = v.un_delay;
    un_len     = v.un_len;
    hs_cnt     = 0;
    done_cnt   = 0;
    first_done = -1;
    mv_seen    = 0;
    accepted   = 1'b0;
    req_mode   = v.mode;
    req_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      go = (req_ready === 1'b1);
      step();
      if (go) begin
        accepted = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    req_mode  = ~v.mode;
    check({tag, "_accept"}, accepted, 1);
    if (reconfig) begin
      check({tag, "_error_cleared"}, error, 0);
    end else begin
      check({tag, "_same_mode_done"}, done, 1);
      check({tag, "_ready_low_on_done"}, req_ready, 0);
    end
    for (int i = 0; i < 4000; i++) begin
      if (req_ready === 1'b1) break;
      step();
    end
    check({tag, "_complete"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_handshakes"}, hs_cnt, v.exp_hs);
    check({tag, "_done_count"}, done_cnt, v.exp_done ? 1 : 0);
    check({tag, "_error"}, error, v.exp_err);
    check({tag, "_cur_mode"}, cur_mode, v.exp_cur);
    check({tag, "_cur_mode_valid"}, cur_mode_valid, v.exp_cur_valid);
    check({tag, "_m_baddr"}, m_baddr, reconfig ? v.mode : model_baddr);
    check({tag, "_m_count"}, m_count, CFG);
    if (!reconfig) check({tag, "_no_m_valid"}, mv_seen, 0);
    if (reconfig && v.kind == K_OK) begin
      if (glitch_off > 0) check_range({tag, "_done_after_glitch"}, first_done - glitch_at, SC + 2, SC + 6);
      else                check_range({tag, "_done_after_relock"}, first_done - lo_end, SC + 1, SC + 5);
    end
    $display("txn %s: mode=%0d kind=%s hs=%0d done=%0d error=%0b cur_mode=%0d valid=%0b",
             tag, v.mode, v.kind.name(), hs_cnt, done_cnt, error, cur_mode, cur_mode_valid);
    if (reconfig) model_baddr = v.mode;
    model_cur   = v.exp_cur;
    model_valid = v.exp_cur_valid;
    lo_start    = 0;
    lo_end      = 0;
    glitch_at   = -1;
    glitch_off  = 0;
    locked      = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    bit found;
    int r;
    reset = 1'b1; req_valid = 1'b0; req_mode = '0; m_ready = 1'b0; locked = 1'b1;

    tbl[0] = mkv(2'd1, 3, K_OK,       5, 50, 1,      1, 0, 2'd1, 1);
    tbl[1] = mkv(2'd1, 0, K_OK,       0,  1, 0,      1, 0, 2'd1, 1);
    tbl[2] = mkv(2'd2, 0, K_OK,       0,  1, 1,      1, 0, 2'd2, 1);
    tbl[3] = mkv(2'd3, 2, K_NOUNLOCK, 0,  0, 1 + MR, 0, 1, 2'd2, 0);
    tbl[4] = mkv(2'd3, 1, K_OK,      10, 20, 1,      1, 0, 2'd3, 1);
    tbl[5] = mkv(2'd0, 0, K_NOREADY,  0,  0, 0,      0, 1, 2'd3, 0);
    tbl[6] = mkv(2'd3, 0, K_OK,       3,  7, 1,      1, 0, 2'd3, 1);
    tbl[7] = mkv(2'd3, 0, K_OK,       0,  1, 0,      1, 0, 2'd3, 1);
    tbl[8] = mkv(2'd0, 4, K_NOLOCK,   0,  0, 1 + MR, 0, 1, 2'd3, 0);
    tbl[9] = mkv(2'd0, 5, K_OK,      20, 60, 1,      1, 0, 2'd0, 1);

    do_boot("boot0");

    for (int i = 0; i < 10; i++) begin
      run_req($sformatf("tbl%0d", i), tbl[i]);
    end

    // Lock glitch 20 cycles into SETTLE.
    glitch_off = 20;
    v = mkv(model_cur + 1'b1, 2, K_OK, 4, 30, 1, 1, 0, model_cur + 1'b1, 1);
    run_req("glitch", v);

    // Reset while the engine request is pending.
    cur_kind  = K_NOREADY;
    cur_delay = 1 << 30;
    req_mode  = model_cur + 1'b1;
    req_valid = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      req_valid = 1'b0;
      if (m_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_issue_reached", found, 1);
    reset = 1'b1;
    step();
    check_reset_vals("mid_issue_reset");
    do_boot("boot1");

    for (int i = 0; i < 20; i++) begin
      v.mode      = RSEL'($urandom_range(0, 3));
      v.eng_delay = $urandom_range(0, 5);
      v.un_delay  = $urandom_range(0, 20);
      v.un_len    = $urandom_range(1, 60);
      r = $urandom_range(0, 9);
      v.kind = (r < 7) ? K_OK : (r == 7) ? K_NOUNLOCK : (r == 8) ? K_NOLOCK : K_NOREADY;
      v = predict(v);
      run_req($sformatf("rnd%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
